// File: rtl/tcam_pkg.sv
`default_nettype none
//==============================================================================
// Module   : tcam_pkg
// Brief    : Shared widths, loader state encoding and the rule record type
//            for the tcam rule loader and its FIFO.
// Revision : 1.0 - initial release
//==============================================================================
package tcam_pkg;

  localparam int KWID     = 104;                 // key width
  localparam int MASKWID  = KWID / 8;            // byte-mask width
  localparam int PRIOR    = 8;                   // priority width
  localparam int IDWID    = 8;                   // rule ID width
  localparam int TOTALWID = KWID + MASKWID + PRIOR; // {prior, mask, key}

  // Loader sequencing states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    HOLD = 3'd2,
    WAIT = 3'd3,
    GAP  = 3'd4
  } loader_state_t;

  // One queued rule write: ID on top, set string below
  typedef struct packed {
    logic [IDWID-1:0]    id;
    logic [TOTALWID-1:0] str;
  } rule_t;

  localparam int RULE_W = $bits(rule_t);

endpackage : tcam_pkg
`default_nettype wire

// File: rtl/tcam_rule_fifo.sv
`default_nettype none
//==============================================================================
// Module   : tcam_rule_fifo
// Brief    : Synchronous FIFO, depth 1<<FDEPTH_LOG2, with pointer-derived
//            level/full/empty. Pointers carry one extra wrap bit so that full
//            and empty are distinguishable. Head data is read combinationally.
// Revision : 1.0 - initial release
//==============================================================================
module tcam_rule_fifo #(
  parameter int WIDTH       = 8,
  parameter int FDEPTH_LOG2 = 2
) (
  input  logic                   clk,
  input  logic                   rst,      // asynchronous, active-low
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [FDEPTH_LOG2:0]   o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int DEPTH = 1 << FDEPTH_LOG2;
  localparam logic [FDEPTH_LOG2:0] C_DEPTH = {1'b1, {FDEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [FDEPTH_LOG2:0] r_wr_ptr;
  logic [FDEPTH_LOG2:0] r_rd_ptr;
  logic                 w_push;
  logic                 w_pop;

  // Occupancy is the modulo-2*depth pointer distance
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_level == C_DEPTH);
  assign o_empty = (r_wr_ptr == r_rd_ptr);

  // A pop frees a slot in the same edge, so a push into a full FIFO is
  // accepted when it coincides with a pop
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  assign o_rdata = r_mem[r_rd_ptr[FDEPTH_LOG2-1:0]];

  // Pointer update; reset discards any stored contents
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate them
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[FDEPTH_LOG2-1:0]] <= i_wdata;
  end

endmodule : tcam_rule_fifo
`default_nettype wire

// File: rtl/tcam_rule_loader.sv
`default_nettype none
//==============================================================================
// Module   : tcam_rule_loader
// Brief    : Buffers rule-write requests from a valid/ready stream and replays
//            them onto the tcam set interface one at a time, holding the set
//            enable for at least SET_HOLD cycles and then waiting for the
//            tcam's done (or a TMO-cycle timeout) before the next rule.
//            Optional build macro TCAM_LOADER_STATS_EN adds saturating
//            completion/timeout counters on two extra output ports.
// Revision : 1.0 - initial release
//==============================================================================
module tcam_rule_loader
  import tcam_pkg::*;
#(
  parameter int FDEPTH_LOG2 = 2,
  parameter int SET_HOLD    = 2,
  parameter int TMO         = 16
) (
  input  logic                  clk,
  input  logic                  rst,            // asynchronous, active-low
  input  logic                  i_Rule_Valid,
  output logic                  o_Rule_Ready,
  input  logic [TOTALWID-1:0]   i_Rule_String,
  input  logic [IDWID-1:0]      i_Rule_ID,
  output logic                  o_Set_Enable,
  output logic [TOTALWID-1:0]   o_Set_String,
  output logic [IDWID-1:0]      o_Set_ID,
  input  logic                  i_Set_Done,
  output logic                  o_Busy,
  output logic                  o_Err_Timeout,
`ifdef TCAM_LOADER_STATS_EN
  output logic [15:0]           o_Stat_Loaded,
  output logic [15:0]           o_Stat_Timeout,
`endif
  output logic [FDEPTH_LOG2:0]  o_Level
);

  // Counter must reach both SET_HOLD and TMO-1
  localparam int CNT_MAX = (SET_HOLD > TMO) ? SET_HOLD : TMO;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] C_HOLD_END = CNT_W'(SET_HOLD);
  localparam logic [CNT_W-1:0] C_TMO_END  = CNT_W'(TMO - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  loader_state_t     r_state;
  logic [CNT_W-1:0]  r_cnt;

  rule_t             w_wr_rule;
  rule_t             w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_done_hit;
  logic              w_tmo_hit;

  assign w_wr_rule    = {i_Rule_ID, i_Rule_String};
  assign o_Rule_Ready = ~w_full;
  assign w_push       = i_Rule_Valid & o_Rule_Ready;
  // Head is consumed only when the sequencer is idle
  assign w_pop        = (r_state == IDLE) & ~w_empty;
  assign o_Busy       = ~w_empty | (r_state != IDLE);

  // Done is only honoured in WAIT; a done during HOLD is deliberately ignored
  assign w_done_hit   = (r_state == WAIT) & i_Set_Done;
  assign w_tmo_hit    = (r_state == WAIT) & ~i_Set_Done & (r_cnt == C_TMO_END);

  tcam_rule_fifo #(
    .WIDTH       (RULE_W),
    .FDEPTH_LOG2 (FDEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wr_rule),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_level (o_Level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Set-interface sequencer: IDLE pops, LOAD raises enable, HOLD enforces
  // the minimum enable width, WAIT watches done/timeout, GAP drops enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      o_Set_Enable  <= 1'b0;
      o_Set_String  <= '0;
      o_Set_ID      <= '0;
      o_Err_Timeout <= 1'b0;
    end else begin
      o_Err_Timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            // String/ID only ever change here, so they are stable
            // throughout the enable window and hold afterwards
            o_Set_String <= w_head.str;
            o_Set_ID     <= w_head.id;
            r_state      <= LOAD;
          end
        end
        LOAD: begin
          o_Set_Enable <= 1'b1;
          r_cnt        <= C_CNT_ONE;
          r_state      <= HOLD;
        end
        HOLD: begin
          if (r_cnt == C_HOLD_END) begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (w_done_hit) begin
            o_Set_Enable <= 1'b0;
            r_cnt        <= '0;
            r_state      <= GAP;
          end else if (w_tmo_hit) begin
            o_Set_Enable  <= 1'b0;
            o_Err_Timeout <= 1'b1;
            r_cnt         <= '0;
            r_state       <= GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          o_Set_Enable <= 1'b0;
          r_cnt        <= '0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

`ifdef TCAM_LOADER_STATS_EN
  // Saturating tallies of completed writes and timed-out writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_Stat_Loaded  <= '0;
      o_Stat_Timeout <= '0;
    end else begin
      if (w_done_hit && (o_Stat_Loaded != 16'hFFFF))
        o_Stat_Loaded <= o_Stat_Loaded + 16'd1;
      if (w_tmo_hit && (o_Stat_Timeout != 16'hFFFF))
        o_Stat_Timeout <= o_Stat_Timeout + 16'd1;
    end
  end
`endif

endmodule : tcam_rule_loader
`default_nettype wire

// File: tb/tb_tcam_rule_loader.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_tcam_rule_loader
// Brief    : Self-checking bench for tcam_rule_loader. A behavioural tcam
//            model answers each write with a per-write done mode; a monitor
//            records every enable window and a table of expected writes is
//            compared against it. Also exercises reset mid-WAIT.
//            Honours TCAM_LOADER_STATS_EN when the design is built with it.
// Revision : 1.0 - initial release
//==============================================================================
module tb_tcam_rule_loader;
  import tcam_pkg::*;

  localparam int FDL      = 2;
  localparam int SET_HOLD = 2;
  localparam int TMO      = 16;
  localparam int NVEC     = 10;
  // Done modes for the tcam model
  localparam int M_NEVER  = 0;   // never answers -> timeout
  localparam int M_HOLD   = 1;   // answers only while still in HOLD
  localparam int M_FAST   = 3;   // answers on the first WAIT cycle

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 rule_valid = 1'b0;
  logic [TOTALWID-1:0]  rule_str = '0;
  logic [IDWID-1:0]     rule_id = '0;
  logic                 set_done = 1'b0;
  logic                 o_Rule_Ready, o_Set_Enable, o_Busy, o_Err_Timeout;
  logic [TOTALWID-1:0]  o_Set_String;
  logic [IDWID-1:0]     o_Set_ID;
  logic [FDL:0]         o_Level;
`ifdef TCAM_LOADER_STATS_EN
  logic [15:0]          o_Stat_Loaded, o_Stat_Timeout;
`endif

  always #5 clk = ~clk;

  tcam_rule_loader #(.FDEPTH_LOG2(FDL), .SET_HOLD(SET_HOLD), .TMO(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_Rule_Valid  (rule_valid),
    .o_Rule_Ready  (o_Rule_Ready),
    .i_Rule_String (rule_str),
    .i_Rule_ID     (rule_id),
    .o_Set_Enable  (o_Set_Enable),
    .o_Set_String  (o_Set_String),
    .o_Set_ID      (o_Set_ID),
    .i_Set_Done    (set_done),
    .o_Busy        (o_Busy),
    .o_Err_Timeout (o_Err_Timeout),
`ifdef TCAM_LOADER_STATS_EN
    .o_Stat_Loaded (o_Stat_Loaded),
    .o_Stat_Timeout(o_Stat_Timeout),
`endif
    .o_Level       (o_Level)
  );

  typedef struct {
    logic [IDWID-1:0]    id;
    logic [TOTALWID-1:0] str;
    int                  mode;
    int                  exp_hi;
    logic                exp_tmo;
  } vec_t;

  typedef struct {
    logic [IDWID-1:0]    id;
    logic [TOTALWID-1:0] str;
    int                  hi;
    logic                tmo;
    int                  gap;
    int                  spacing;
    logic                unstable;
  } wr_t;

  int   nvec = 0;
  int   nfail = 0;
  int   cyc = 0;
  int   wr_idx = 0;
  int   mode_tab [64];
  int   cur_mode = M_FAST;
  int   last_fall = 0;
  int   last_rise = 0;
  int   tmo_pulses = 0;
  int   max_level = 0;
  logic ready_bad = 1'b0;
  logic en_q = 1'b0;
  wr_t  cur;
  wr_t  wq [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // tcam model plus enable-window monitor, all sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (o_Set_Enable) begin
      if (!en_q) begin
        cur.id       = o_Set_ID;
        cur.str      = o_Set_String;
        cur.hi       = 0;
        cur.tmo      = 1'b0;
        cur.unstable = 1'b0;
        cur.gap      = cyc - last_fall;
        cur.spacing  = cyc - last_rise;
        last_rise    = cyc;
        cur_mode     = (wr_idx < 64) ? mode_tab[wr_idx] : M_FAST;
        wr_idx++;
      end
      cur.hi++;
      if (o_Set_ID !== cur.id || o_Set_String !== cur.str) cur.unstable = 1'b1;
      set_done = (cur_mode == M_FAST && cur.hi >= SET_HOLD + 1) ||
                 (cur_mode == M_HOLD && cur.hi <= SET_HOLD);
    end else begin
      set_done = 1'b0;
      if (en_q) begin
        cur.tmo = o_Err_Timeout;
        wq.push_back(cur);
        last_fall = cyc;
      end
    end
    if (o_Err_Timeout) tmo_pulses++;
    if (int'(o_Level) > max_level) max_level = int'(o_Level);
    if (o_Rule_Ready !== (o_Level != 3'd4)) ready_bad = 1'b1;
    en_q = o_Set_Enable;
  end

  // Offer one rule and hold it until accepted (bounded)
  task automatic push(input logic [IDWID-1:0] id, input logic [TOTALWID-1:0] s);
    int guard = 0;
    @(negedge clk);
    rule_valid = 1'b1;
    rule_id    = id;
    rule_str   = s;
    while (!o_Rule_Ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) check("push_accept_timeout", 128'(0), 128'(1));
    @(posedge clk);
  endtask

  task automatic wait_writes(input int n, input string name);
    int guard = 0;
    while (wq.size() < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check(name, 128'(wq.size() >= n), 128'(1));
  endtask

  vec_t vec [NVEC];
  logic [TOTALWID-1:0] first_str;
  wr_t  w;
  int   base;
  int   guard;

  initial begin
    // ---------------- expected-write table ----------------
    for (int i = 0; i < NVEC; i++) begin
      vec[i].id   = 8'(i);
      vec[i].str  = {8'(8'h10 + i), 13'h0AA0 ^ 13'(i), 104'hDEADBEEF_00000000_0000000000 | 104'(i * 3)};
      vec[i].mode = (i == 4) ? M_NEVER : (i == 7) ? M_HOLD : M_FAST;
      vec[i].exp_tmo = (vec[i].mode != M_FAST);
      vec[i].exp_hi  = (vec[i].mode == M_FAST) ? SET_HOLD + 1 : SET_HOLD + TMO;
    end
    for (int i = 0; i < 64; i++) mode_tab[i] = M_FAST;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst_enable", 128'(o_Set_Enable), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_enable_rel", 128'(o_Set_Enable), 128'(0));
    check("rst_string", 128'(o_Set_String), 128'(0));
    check("rst_id", 128'(o_Set_ID), 128'(0));
    check("rst_timeout", 128'(o_Err_Timeout), 128'(0));
    check("rst_busy", 128'(o_Busy), 128'(0));
    check("rst_level", 128'(o_Level), 128'(0));
    check("rst_ready", 128'(o_Rule_Ready), 128'(1));
`ifdef TCAM_LOADER_STATS_EN
    check("rst_stat_loaded", 128'(o_Stat_Loaded), 128'(0));
    check("rst_stat_timeout", 128'(o_Stat_Timeout), 128'(0));
`endif

    // ---------------- first-enable latency ----------------
    first_str = {8'h00, 13'b0001001100000, 104'h405B6A00A468_0000FFFFFFFFFF};
    push(8'h00, first_str);             // push at edge N
    @(negedge clk);
    rule_valid = 1'b0;
    check("lat_level_N", 128'(o_Level), 128'(1));
    check("lat_enable_N", 128'(o_Set_Enable), 128'(0));
    @(negedge clk);
    check("lat_enable_N1", 128'(o_Set_Enable), 128'(0));
    check("lat_busy_N1", 128'(o_Busy), 128'(1));
    @(negedge clk);
    check("lat_enable_N2", 128'(o_Set_Enable), 128'(1));
    check("lat_id", 128'(o_Set_ID), 128'(8'h00));
    check("lat_string", 128'(o_Set_String), 128'(first_str));
    wait_writes(1, "lat_write_done");
    if (wq.size() >= 1) begin
      check("lat_hi_cycles", 128'(wq[0].hi), 128'(SET_HOLD + 1));
      check("lat_no_timeout", 128'(wq[0].tmo), 128'(0));
    end

    // ---------------- table: back-to-back writes ----------------
    repeat (3) @(negedge clk);
    wq.delete();
    wr_idx     = 0;
    tmo_pulses = 0;
    max_level  = 0;
    ready_bad  = 1'b0;
    for (int i = 0; i < NVEC; i++) mode_tab[i] = vec[i].mode;
    for (int i = 0; i < NVEC; i++) push(vec[i].id, vec[i].str);
    @(negedge clk);
    rule_valid = 1'b0;
    wait_writes(NVEC, "tab_all_writes");
    for (int i = 0; i < NVEC && i < wq.size(); i++) begin
      w = wq[i];
      check($sformatf("tab%0d_id", i), 128'(w.id), 128'(vec[i].id));
      check($sformatf("tab%0d_str", i), 128'(w.str), 128'(vec[i].str));
      check($sformatf("tab%0d_hi", i), 128'(w.hi), 128'(vec[i].exp_hi));
      check($sformatf("tab%0d_tmo", i), 128'(w.tmo), 128'(vec[i].exp_tmo));
      check($sformatf("tab%0d_stable", i), 128'(w.unstable), 128'(0));
      if (i > 0)
        check($sformatf("tab%0d_spacing", i),
              128'((w.gap >= 1) && (w.spacing >= SET_HOLD + 2)), 128'(1));
    end
    repeat (4) @(negedge clk);
    check("tab_timeout_pulses", 128'(tmo_pulses), 128'(2));
    check("tab_max_level", 128'(max_level), 128'(4));
    check("tab_ready_vs_level", 128'(ready_bad), 128'(0));
    check("tab_idle_busy", 128'(o_Busy), 128'(0));
    check("tab_idle_level", 128'(o_Level), 128'(0));
    check("tab_hold_id", 128'(o_Set_ID), 128'(vec[NVEC-1].id));
`ifdef TCAM_LOADER_STATS_EN
    check("tab_stat_loaded", 128'(o_Stat_Loaded), 128'(9));
    check("tab_stat_timeout", 128'(o_Stat_Timeout), 128'(2));
`endif

    // ---------------- reset mid-WAIT with 3 queued ----------------
    wq.delete();
    wr_idx = 0;
    for (int i = 0; i < 8; i++) mode_tab[i] = M_NEVER;
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), vec[i].str);
    @(negedge clk);
    rule_valid = 1'b0;
    guard = 0;
    while (!(o_Set_Enable && cur.hi >= SET_HOLD + 3 && o_Level == 3'd3) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("rstw_reached_wait", 128'(guard < 100), 128'(1));
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rstw_enable_async", 128'(o_Set_Enable), 128'(0));
    check("rstw_level", 128'(o_Level), 128'(0));
    check("rstw_busy", 128'(o_Busy), 128'(0));
    check("rstw_ready", 128'(o_Rule_Ready), 128'(1));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    base = wr_idx;
    repeat (40) @(negedge clk);
    check("rstw_no_stale_writes", 128'(wr_idx - base), 128'(0));
    check("rstw_level_after", 128'(o_Level), 128'(0));
`ifdef TCAM_LOADER_STATS_EN
    check("rstw_stat_loaded", 128'(o_Stat_Loaded), 128'(0));
    check("rstw_stat_timeout", 128'(o_Stat_Timeout), 128'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  // Global bound so the run can never hang
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule : tb_tcam_rule_loader
`default_nettype wire
